execute_stage: RTL and testbench



---
 rtl/execute_stage.sv | 72 +++++++
 tb/tb_execute_stage.sv | 92 +++++++++
 2 files changed

// File: rtl/execute_stage.sv
// execute_stage: Y86-64 execute stage computing valE, CC register and branch/cmov condition
module SUB #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] d,
  output logic         co
);
  assign {co, d} = {1'b0, a} - {1'b0, b};
endmodule

module execute_stage #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [3:0]   icode,
  input  logic [3:0]   ifun,
  input  logic [W-1:0] valA,
  input  logic [W-1:0] valB,
  input  logic [W-1:0] valC,
  input  logic         stat_ok,
  output logic         out_valid,
  output logic [W-1:0] valE,
  output logic         cnd,
  output logic [2:0]   cc,
  output logic         err
);
  logic [W-1:0] sub_b, diff, opres, vale_n;
  logic unused_co, op_ill, jc_ill, of_n, cond, cnd_n, zf, sf, of;
  assign {zf, sf, of} = cc;
  SUB #(.W(W)) u_sub (.a(valB), .b(sub_b), .d(diff), .co(unused_co));
  // ALU result, overflow, condition evaluation and illegal-ifun detection
  always_comb begin
    sub_b = icode == 4'h6 ? valA : W'(8);
    op_ill = icode == 4'h6 && ifun > 4'd3;
    jc_ill = (icode == 4'h2 || icode == 4'h7) && ifun > 4'd6;
    opres = ifun == 4'd0 ? valB + valA : ifun == 4'd1 ? diff : ifun == 4'd2 ? valB & valA : valB ^ valA;
    of_n = ifun == 4'd0 ? (valA[W-1] == valB[W-1]) && (opres[W-1] != valB[W-1]) :
           ifun == 4'd1 ? (valB[W-1] != valA[W-1]) && (opres[W-1] != valB[W-1]) : 1'b0;
    cond = ifun == 4'd0 ? 1'b1 : ifun == 4'd1 ? (sf ^ of) | zf : ifun == 4'd2 ? sf ^ of :
           ifun == 4'd3 ? zf : ifun == 4'd4 ? ~zf : ifun == 4'd5 ? ~(sf ^ of) : ~(sf ^ of) & ~zf;
    cnd_n = (op_ill || jc_ill) ? 1'b0 : (icode == 4'h2 || icode == 4'h7) ? cond : 1'b1;
    vale_n = (op_ill || jc_ill) ? '0 :
             icode == 4'h2 ? valA :
             icode == 4'h3 ? valC :
             (icode == 4'h4 || icode == 4'h5) ? valB + valC :
             icode == 4'h6 ? opres :
             (icode == 4'h8 || icode == 4'hA) ? diff :
             (icode == 4'h9 || icode == 4'hB) ? valB + W'(8) : '0;
  end
  // Result registers and CC; CC only written by legal OPq with good status
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      valE <= '0;
      cnd <= 1'b0;
      err <= 1'b0;
      cc <= 3'b100;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        valE <= vale_n;
        cnd <= cnd_n;
        err <= op_ill || jc_ill;
        if (icode == 4'h6 && !op_ill && stat_ok) cc <= {opres == '0, opres[W-1], of_n};
      end
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: table-driven directed check of execute_stage
module tb_execute_stage;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, stat_ok = 1'b1;
  logic [3:0] icode = '0, ifun = '0;
  logic [63:0] valA = '0, valB = '0, valC = '0;
  logic out_valid, cnd, err;
  logic [63:0] valE;
  logic [2:0] cc;
  int checks = 0, errors = 0;
  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  typedef struct {
    logic rst_n, in_valid;
    logic [3:0] icode, ifun;
    logic [63:0] a, b, c;
    logic ok, ov;
    logic [63:0] e;
    logic cnd;
    logic [2:0] cc;
    logic err;
  } vec_t;
  vec_t v[$];

  execute_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .icode(icode), .ifun(ifun),
    .valA(valA), .valB(valB), .valC(valC), .stat_ok(stat_ok),
    .out_valid(out_valid), .valE(valE), .cnd(cnd), .cc(cc), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t x, input int idx);
    rst_n = x.rst_n; in_valid = x.in_valid; icode = x.icode; ifun = x.ifun;
    valA = x.a; valB = x.b; valC = x.c; stat_ok = x.ok;
    @(posedge clk);
    #1;
    chk("out_valid", idx, 64'(out_valid), 64'(x.ov));
    chk("valE", idx, valE, x.e);
    chk("cnd", idx, 64'(cnd), 64'(x.cnd));
    chk("cc", idx, 64'(cc), 64'(x.cc));
    chk("err", idx, 64'(err), 64'(x.err));
  endtask

  initial begin
    // rst_n in_valid icode ifun valA valB valC ok | ov valE cnd cc err
    v.push_back('{0, 1, 4'h6, 4'h1, 64'd10, 64'd15, 64'd0, 1, 0, 64'd0, 0, 3'b100, 0});
    v.push_back('{0, 1, 4'h6, 4'h1, 64'd10, 64'd15, 64'd0, 1, 0, 64'd0, 0, 3'b100, 0});
    v.push_back('{1, 1, 4'h6, 4'h1, 64'd10, 64'd15, 64'd0, 1, 1, 64'd5, 1, 3'b000, 0});
    v.push_back('{1, 1, 4'h6, 4'h1, 64'd15, 64'd10, 64'd0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFB, 1, 3'b010, 0});
    v.push_back('{1, 1, 4'h6, 4'h0, 64'd1, MAXP, 64'd0, 1, 1, MINN, 1, 3'b011, 0});
    v.push_back('{1, 1, 4'h6, 4'h1, 64'd1, MINN, 64'd0, 1, 1, MAXP, 1, 3'b001, 0});
    v.push_back('{1, 1, 4'h6, 4'h1, 64'd10, 64'd10, 64'd0, 1, 1, 64'd0, 1, 3'b100, 0});
    v.push_back('{1, 1, 4'h7, 4'h0, 64'd0, 64'd0, 64'd0, 1, 1, 64'd0, 1, 3'b100, 0});
    v.push_back('{1, 1, 4'h7, 4'h1, 64'd0, 64'd0, 64'd0, 1, 1, 64'd0, 1, 3'b100, 0});
    v.push_back('{1, 1, 4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 1, 1, 64'd0, 0, 3'b100, 0});
    v.push_back('{1, 1, 4'h7, 4'h3, 64'd0, 64'd0, 64'd0, 1, 1, 64'd0, 1, 3'b100, 0});
    v.push_back('{1, 1, 4'h7, 4'h4, 64'd0, 64'd0, 64'd0, 1, 1, 64'd0, 0, 3'b100, 0});
    v.push_back('{1, 1, 4'h7, 4'h5, 64'd0, 64'd0, 64'd0, 1, 1, 64'd0, 1, 3'b100, 0});
    v.push_back('{1, 1, 4'h7, 4'h6, 64'd0, 64'd0, 64'd0, 1, 1, 64'd0, 0, 3'b100, 0});
    v.push_back('{1, 1, 4'h2, 4'h3, 64'h1234, 64'd0, 64'd0, 1, 1, 64'h1234, 1, 3'b100, 0});
    v.push_back('{1, 1, 4'hA, 4'h0, 64'd0, 64'h100, 64'd0, 1, 1, 64'hF8, 1, 3'b100, 0});
    v.push_back('{1, 1, 4'hB, 4'h0, 64'd0, 64'h100, 64'd0, 1, 1, 64'h108, 1, 3'b100, 0});
    v.push_back('{1, 1, 4'h5, 4'h0, 64'd0, 64'h20, 64'h8, 1, 1, 64'h28, 1, 3'b100, 0});
    v.push_back('{1, 1, 4'h6, 4'h5, 64'd3, 64'd4, 64'd0, 1, 1, 64'd0, 0, 3'b100, 1});
    v.push_back('{1, 1, 4'h7, 4'h7, 64'd3, 64'd4, 64'd0, 1, 1, 64'd0, 0, 3'b100, 1});
    v.push_back('{1, 1, 4'h6, 4'h3, 64'd0, MINN, 64'd0, 1, 1, MINN, 1, 3'b010, 0});
    v.push_back('{1, 1, 4'h6, 4'h0, ONES, 64'd1, 64'd0, 0, 1, 64'd0, 1, 3'b010, 0});
    v.push_back('{1, 1, 4'h6, 4'h2, 64'h0F, 64'hF0, 64'd0, 1, 1, 64'd0, 1, 3'b100, 0});
    v.push_back('{1, 1, 4'h6, 4'h0, 64'd2, 64'd3, 64'd0, 1, 1, 64'd5, 1, 3'b000, 0});
    v.push_back('{1, 1, 4'h7, 4'h6, 64'd0, 64'd0, 64'd0, 1, 1, 64'd0, 1, 3'b000, 0});
    v.push_back('{1, 1, 4'h3, 4'h0, 64'd0, 64'd0, 64'hABCD, 1, 1, 64'hABCD, 1, 3'b000, 0});
    v.push_back('{1, 0, 4'h6, 4'h1, 64'd9, 64'd1, 64'd0, 1, 0, 64'hABCD, 1, 3'b000, 0});
    v.push_back('{1, 1, 4'h4, 4'h0, 64'd0, 64'h1000, 64'hFFFF_FFFF_FFFF_FFF0, 1, 1, 64'hFF0, 1, 3'b000, 0});
    foreach (v[i]) apply(v[i], i);
    // mid-stream reset: sub 1-5 (SF set) is dropped, then je sees the reset CC
    apply('{1, 1, 4'h6, 4'h1, 64'd5, 64'd1, 64'd0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 3'b010, 0}, 100);
    apply('{0, 1, 4'h6, 4'h1, 64'd5, 64'd1, 64'd0, 1, 0, 64'd0, 0, 3'b100, 0}, 101);
    apply('{1, 1, 4'h7, 4'h3, 64'd0, 64'd0, 64'd0, 1, 1, 64'd0, 1, 3'b100, 0}, 102);
    apply('{1, 1, 4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 1, 1, 64'd0, 0, 3'b100, 0}, 103);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
